ax_hazard_scoreboard: RTL and testbench

- Issue-side hazard controller for the pipelined BPF CPU's A/X register writeback path.
- Counts in-flight writes to A and X from stage-1 issue until the stage-3 writeback enables retire them.
- Stalls stage 1 on read-after-write hazards and on counter saturation.
- Provides a drain/halt sequencer for RET/reload, plus a stall-cycle performance counter.

---
 rtl/ax_hazard_scoreboard.sv | 142 ++++++++++++++
 tb/tb_ax_hazard_scoreboard.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ax_hazard_scoreboard.sv
// Issue-side A/X writeback hazard scoreboard: in-flight counters, issue stall, drain/halt sequencer, stall counter.
// Build option AX_FORWARD_EN adds fwd_A/fwd_X and waives a read hazard whose last pending write lands this cycle.
module ax_hazard_scoreboard #(
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_rd_A,
  input  logic             issue_rd_X,
  input  logic             issue_wr_A,
  input  logic             issue_wr_X,
  input  logic             wb_A_en,
  input  logic             wb_X_en,
  input  logic             drain_req,
  input  logic             resume,
  input  logic             cnt_clr,
  output logic             stall,
  output logic             issue_accept,
  output logic             drained,
  output logic             sb_err,
`ifdef AX_FORWARD_EN
  output logic             fwd_A,
  output logic             fwd_X,
`endif
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned       PEND_W   = 2;
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_INFLIGHT);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [PEND_W-1:0] pend_a_q;
  logic [PEND_W-1:0] pend_x_q;
  logic [PEND_W-1:0] pend_a_d;
  logic [PEND_W-1:0] pend_x_d;
  logic              rd_haz_a;
  logic              rd_haz_x;
  logic              sat_a;
  logic              sat_x;
  logic              inc_a;
  logic              inc_x;
  logic              underflow;
`ifdef AX_FORWARD_EN
  logic              fwd_a_c;
  logic              fwd_x_c;
`endif

  // Underflow holds the counter at zero, but a same-cycle issue still counts.
  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] p,
                                                   input logic              inc,
                                                   input logic              dec);
    logic [PEND_W-1:0] n;
    if (dec && (p == '0)) n = PEND_W'(inc);
    else                  n = p + PEND_W'(inc) - PEND_W'(dec);
    return n;
  endfunction

  // Hazard detection and issue handshake.
  always_comb begin
    rd_haz_a = issue_rd_A & (pend_a_q != '0);
    rd_haz_x = issue_rd_X & (pend_x_q != '0);
`ifdef AX_FORWARD_EN
    fwd_a_c  = issue_valid & issue_rd_A & (pend_a_q == PEND_ONE) & wb_A_en;
    fwd_x_c  = issue_valid & issue_rd_X & (pend_x_q == PEND_ONE) & wb_X_en;
    rd_haz_a = rd_haz_a & ~fwd_a_c;
    rd_haz_x = rd_haz_x & ~fwd_x_c;
`endif
    sat_a        = issue_wr_A & (pend_a_q == PEND_MAX);
    sat_x        = issue_wr_X & (pend_x_q == PEND_MAX);
    stall        = issue_valid & ((state_q != ST_RUN) | rd_haz_a | rd_haz_x | sat_a | sat_x);
    issue_accept = issue_valid & ~stall;
  end

`ifdef AX_FORWARD_EN
  assign fwd_A = fwd_a_c;
  assign fwd_X = fwd_x_c;
`endif

  // In-flight counter next values; writebacks retire in every state.
  always_comb begin
    inc_a     = issue_accept & issue_wr_A;
    inc_x     = issue_accept & issue_wr_X;
    pend_a_d  = pend_next(pend_a_q, inc_a, wb_A_en);
    pend_x_d  = pend_next(pend_x_q, inc_x, wb_X_en);
    underflow = (wb_A_en & (pend_a_q == '0)) | (wb_X_en & (pend_x_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_a_q <= '0;
      pend_x_q <= '0;
      sb_err   <= 1'b0;
    end else begin
      pend_a_q <= pend_a_d;
      pend_x_q <= pend_x_d;
      sb_err   <= sb_err | underflow;
    end
  end

  // Drain/halt sequencer: each state only listens to the pulse that can leave it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN:  if ((pend_a_q == '0) && (pend_x_q == '0)) state_d = ST_HALTED;
      ST_HALTED: if (resume) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      drained <= 1'b0;
    end else begin
      state_q <= state_d;
      drained <= (state_d == ST_HALTED);
    end
  end

  // Saturating stall-cycle counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (cnt_clr) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ax_hazard_scoreboard.sv
// Self-checking bench for ax_hazard_scoreboard; expectations flow through a queue from stimulus to sampling point.
module tb_ax_hazard_scoreboard;

  localparam logic [9:0] IDLE = 10'h000;
  localparam logic [9:0] V    = 10'h001;
  localparam logic [9:0] RDA  = 10'h002;
  localparam logic [9:0] RDX  = 10'h004;
  localparam logic [9:0] WRA  = 10'h008;
  localparam logic [9:0] WRX  = 10'h010;
  localparam logic [9:0] WBA  = 10'h020;
  localparam logic [9:0] WBX  = 10'h040;
  localparam logic [9:0] DRQ  = 10'h080;
  localparam logic [9:0] RES  = 10'h100;
  localparam logic [9:0] CLR  = 10'h200;
`ifdef AX_FORWARD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] stim;
    logic       stall;
    logic [1:0] pa;
    logic [1:0] px;
    logic       dr;
    logic       err;
  } row_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_rd_A, issue_rd_X, issue_wr_A, issue_wr_X;
  logic        wb_A_en, wb_X_en, drain_req, resume, cnt_clr;
  logic        stall, issue_accept, drained, sb_err;
  logic        stall4, accept4, drained4, sb_err4;
  logic [31:0] stall_cycles;
  logic [3:0]  stall_cycles4;
`ifdef AX_FORWARD_EN
  logic        fwd_A, fwd_X, fwd4_A, fwd4_X;
`endif

  int   checks   = 0;
  int   failures = 0;
  row_t exp_q[$];
  int unsigned cnt_q[$];

  always #5 clk = ~clk;

  ax_hazard_scoreboard #(.MAX_INFLIGHT(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd_A(issue_rd_A), .issue_rd_X(issue_rd_X),
    .issue_wr_A(issue_wr_A), .issue_wr_X(issue_wr_X), .wb_A_en(wb_A_en), .wb_X_en(wb_X_en),
    .drain_req(drain_req), .resume(resume), .cnt_clr(cnt_clr), .stall(stall), .issue_accept(issue_accept),
    .drained(drained), .sb_err(sb_err),
`ifdef AX_FORWARD_EN
    .fwd_A(fwd_A), .fwd_X(fwd_X),
`endif
    .stall_cycles(stall_cycles)
  );

  ax_hazard_scoreboard #(.MAX_INFLIGHT(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd_A(issue_rd_A), .issue_rd_X(issue_rd_X),
    .issue_wr_A(issue_wr_A), .issue_wr_X(issue_wr_X), .wb_A_en(wb_A_en), .wb_X_en(wb_X_en),
    .drain_req(drain_req), .resume(resume), .cnt_clr(cnt_clr), .stall(stall4), .issue_accept(accept4),
    .drained(drained4), .sb_err(sb_err4),
`ifdef AX_FORWARD_EN
    .fwd_A(fwd4_A), .fwd_X(fwd4_X),
`endif
    .stall_cycles(stall_cycles4)
  );

  function automatic row_t mk(input logic [9:0] s, input logic st, input logic [1:0] pa,
                              input logic [1:0] px, input logic dr, input logic err);
    row_t r;
    r.stim = s; r.stall = st; r.pa = pa; r.px = px; r.dr = dr; r.err = err;
    return r;
  endfunction

  task automatic apply(input logic [9:0] s);
    issue_valid = s[0]; issue_rd_A = s[1]; issue_rd_X = s[2]; issue_wr_A = s[3]; issue_wr_X = s[4];
    wb_A_en = s[5]; wb_X_en = s[6]; drain_req = s[7]; resume = s[8]; cnt_clr = s[9];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(IDLE);
    tick();
    tick();
    rst = 1'b0;
    checks++; if (drained !== 1'b0) begin failures++; $display("FAIL reset_drained got %b want 0", drained); end
    checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL reset_sb_err got %b want 0", sb_err); end
    checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL reset_cnt got %0d want 0", stall_cycles); end
    checks++; if (dut.pend_a_q !== 2'd0 || dut.pend_x_q !== 2'd0) begin
      failures++; $display("FAIL reset_pend got a=%0d x=%0d want 0/0", dut.pend_a_q, dut.pend_x_q);
    end
    checks++; if (stall !== 1'b0 || issue_accept !== 1'b0) begin
      failures++; $display("FAIL reset_stall got stall=%b accept=%b want 0/0", stall, issue_accept);
    end
  endtask

  task automatic test_raw_hazard();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(V | WRA,       1'b0, 2'd1, 2'd0, 1'b0, 1'b0));
    rows.push_back(mk(V | RDA,       1'b1, 2'd1, 2'd0, 1'b0, 1'b0));
    rows.push_back(mk(V | RDA | WBA, ~FWD, 2'd0, 2'd0, 1'b0, 1'b0));
    rows.push_back(mk(V | RDA,       1'b0, 2'd0, 2'd0, 1'b0, 1'b0));
    rows.push_back(mk(IDLE,          1'b0, 2'd0, 2'd0, 1'b0, 1'b0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i].stim);
      exp_q.push_back(rows[i]);
      #1;
      e = exp_q.pop_front();
      checks++; if (stall !== e.stall) begin failures++; $display("FAIL raw[%0d] stall got %b want %b", i, stall, e.stall); end
      checks++; if (issue_accept !== (e.stim[0] & ~e.stall)) begin
        failures++; $display("FAIL raw[%0d] accept got %b want %b", i, issue_accept, e.stim[0] & ~e.stall);
      end
`ifdef AX_FORWARD_EN
      checks++; if (fwd_A !== (i == 2)) begin failures++; $display("FAIL raw[%0d] fwd_A got %b want %b", i, fwd_A, i == 2); end
`endif
      tick();
      checks++; if (dut.pend_a_q !== e.pa || dut.pend_x_q !== e.px) begin
        failures++; $display("FAIL raw[%0d] pend got a=%0d x=%0d want a=%0d x=%0d", i, dut.pend_a_q, dut.pend_x_q, e.pa, e.px);
      end
    end
  endtask

  task automatic test_saturation();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(V | WRX,       1'b0, 2'd0, 2'd1, 1'b0, 1'b0));
    rows.push_back(mk(V | WRX,       1'b0, 2'd0, 2'd2, 1'b0, 1'b0));
    rows.push_back(mk(V | WRX,       1'b1, 2'd0, 2'd2, 1'b0, 1'b0));
    rows.push_back(mk(V | WRX | WBX, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0));
    rows.push_back(mk(V | WRX,       1'b0, 2'd0, 2'd2, 1'b0, 1'b0));
    rows.push_back(mk(WBX,           1'b0, 2'd0, 2'd1, 1'b0, 1'b0));
    rows.push_back(mk(WBX,           1'b0, 2'd0, 2'd0, 1'b0, 1'b0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i].stim);
      exp_q.push_back(rows[i]);
      #1;
      e = exp_q.pop_front();
      checks++; if (stall !== e.stall) begin failures++; $display("FAIL sat[%0d] stall got %b want %b", i, stall, e.stall); end
      checks++; if (issue_accept !== (e.stim[0] & ~e.stall)) begin
        failures++; $display("FAIL sat[%0d] accept got %b want %b", i, issue_accept, e.stim[0] & ~e.stall);
      end
      tick();
      checks++; if (dut.pend_a_q !== e.pa || dut.pend_x_q !== e.px) begin
        failures++; $display("FAIL sat[%0d] pend got a=%0d x=%0d want a=%0d x=%0d", i, dut.pend_a_q, dut.pend_x_q, e.pa, e.px);
      end
    end
  endtask

  task automatic test_simultaneous();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(V | WRA,       1'b0, 2'd1, 2'd0, 1'b0, 1'b0));
    rows.push_back(mk(V | WRA | WBA, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0));
    rows.push_back(mk(WBA,           1'b0, 2'd0, 2'd0, 1'b0, 1'b0));
    rows.push_back(mk(WBX,           1'b0, 2'd0, 2'd0, 1'b0, 1'b1));
    rows.push_back(mk(V | WRX | WBX, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1));
    rows.push_back(mk(WBX,           1'b0, 2'd0, 2'd0, 1'b0, 1'b1));
    rows.push_back(mk(IDLE,          1'b0, 2'd0, 2'd0, 1'b0, 1'b1));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i].stim);
      exp_q.push_back(rows[i]);
      #1;
      e = exp_q.pop_front();
      checks++; if (issue_accept !== (e.stim[0] & ~e.stall)) begin
        failures++; $display("FAIL simul[%0d] accept got %b want %b", i, issue_accept, e.stim[0] & ~e.stall);
      end
      tick();
      checks++; if (dut.pend_a_q !== e.pa || dut.pend_x_q !== e.px) begin
        failures++; $display("FAIL simul[%0d] pend got a=%0d x=%0d want a=%0d x=%0d", i, dut.pend_a_q, dut.pend_x_q, e.pa, e.px);
      end
      checks++; if (sb_err !== e.err) begin failures++; $display("FAIL simul[%0d] sb_err got %b want %b", i, sb_err, e.err); end
    end
  endtask

  task automatic test_drain();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(V | WRA,             1'b0, 2'd1, 2'd0, 1'b0, 1'b1));
    rows.push_back(mk(V | WRA,             1'b0, 2'd2, 2'd0, 1'b0, 1'b1));
    rows.push_back(mk(DRQ,                 1'b0, 2'd2, 2'd0, 1'b0, 1'b1));
    rows.push_back(mk(V | RDX | WBA,       1'b1, 2'd1, 2'd0, 1'b0, 1'b1));
    rows.push_back(mk(V | RDX | WBA,       1'b1, 2'd0, 2'd0, 1'b0, 1'b1));
    rows.push_back(mk(V | RDX | DRQ | RES, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1));
    rows.push_back(mk(V | RDX | DRQ | RES, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1));
    rows.push_back(mk(V | RDX,             1'b0, 2'd0, 2'd0, 1'b0, 1'b1));
    rows.push_back(mk(DRQ,                 1'b0, 2'd0, 2'd0, 1'b0, 1'b1));
    rows.push_back(mk(IDLE,                1'b0, 2'd0, 2'd0, 1'b1, 1'b1));
    rows.push_back(mk(V | WRA,             1'b1, 2'd0, 2'd0, 1'b1, 1'b1));
    rows.push_back(mk(RES,                 1'b0, 2'd0, 2'd0, 1'b0, 1'b1));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i].stim);
      exp_q.push_back(rows[i]);
      #1;
      e = exp_q.pop_front();
      checks++; if (stall !== e.stall) begin failures++; $display("FAIL drain[%0d] stall got %b want %b", i, stall, e.stall); end
      checks++; if (issue_accept !== (e.stim[0] & ~e.stall)) begin
        failures++; $display("FAIL drain[%0d] accept got %b want %b", i, issue_accept, e.stim[0] & ~e.stall);
      end
      tick();
      checks++; if (drained !== e.dr) begin failures++; $display("FAIL drain[%0d] drained got %b want %b", i, drained, e.dr); end
      checks++; if (dut.pend_a_q !== e.pa) begin failures++; $display("FAIL drain[%0d] pend_a got %0d want %0d", i, dut.pend_a_q, e.pa); end
    end
  endtask

  task automatic test_stall_counter();
    int unsigned exp_cnt;
    apply(CLR);
    cnt_q.push_back(0);
    tick();
    exp_cnt = cnt_q.pop_front();
    checks++; if (stall_cycles !== exp_cnt) begin failures++; $display("FAIL cnt_clr0 got %0d want %0d", stall_cycles, exp_cnt); end
    apply(V | WRA);
    tick();
    repeat (5) begin apply(V | RDA); tick(); end
    cnt_q.push_back(5);
    apply(IDLE);
    exp_cnt = cnt_q.pop_front();
    checks++; if (stall_cycles !== exp_cnt) begin failures++; $display("FAIL cnt_five got %0d want %0d", stall_cycles, exp_cnt); end
    checks++; if (stall_cycles4 !== 4'(exp_cnt)) begin failures++; $display("FAIL cnt4_five got %0d want %0d", stall_cycles4, exp_cnt); end
    apply(V | RDA | CLR);
    cnt_q.push_back(0);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL cnt_clr_stall got %b want 1", stall); end
    tick();
    exp_cnt = cnt_q.pop_front();
    checks++; if (stall_cycles !== exp_cnt) begin failures++; $display("FAIL cnt_clr_prio got %0d want %0d", stall_cycles, exp_cnt); end
    repeat (20) begin apply(V | RDA); tick(); end
    cnt_q.push_back(20);
    cnt_q.push_back(15);
    apply(IDLE);
    exp_cnt = cnt_q.pop_front();
    checks++; if (stall_cycles !== exp_cnt) begin failures++; $display("FAIL cnt_twenty got %0d want %0d", stall_cycles, exp_cnt); end
    exp_cnt = cnt_q.pop_front();
    checks++; if (stall_cycles4 !== 4'(exp_cnt)) begin failures++; $display("FAIL cnt4_sat got %0d want %0d", stall_cycles4, exp_cnt); end
    apply(WBA);
    tick();
    apply(IDLE);
    tick();
    checks++; if (dut.pend_a_q !== 2'd0) begin failures++; $display("FAIL cnt_cleanup pend_a got %0d want 0", dut.pend_a_q); end
  endtask

  task automatic test_reset_mid_drain();
    apply(V | WRA);
    tick();
    apply(DRQ);
    tick();
    apply(V | RDX);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rstdrain_pre_stall got %b want 1", stall); end
    apply(IDLE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (dut.pend_a_q !== 2'd0) begin failures++; $display("FAIL rstdrain_pend_a got %0d want 0", dut.pend_a_q); end
    checks++; if (drained !== 1'b0) begin failures++; $display("FAIL rstdrain_drained got %b want 0", drained); end
    checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL rstdrain_cnt got %0d want 0", stall_cycles); end
    checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL rstdrain_sb_err got %b want 0", sb_err); end
    apply(V | RDA);
    #1;
    checks++; if (stall !== 1'b0 || issue_accept !== 1'b1) begin
      failures++; $display("FAIL rstdrain_run got stall=%b accept=%b want 0/1", stall, issue_accept);
    end
    tick();
    apply(IDLE);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    apply(IDLE);
    test_reset();
    test_raw_hazard();
    test_saturation();
    test_simultaneous();
    test_drain();
    test_stall_counter();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
